adc_capture_ctrl: RTL and testbench

ADC_CAPTURE_CTRL -- requirements
Module: adc_capture_ctrl

---
 rtl/adc_capture_ctrl_pkg.sv | 26 ++
 rtl/adc_capture_ctrl_sync.sv | 25 ++
 rtl/adc_capture_ctrl.sv | 149 ++++++++++++++
 tb/tb_adc_capture_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_ctrl_pkg.sv
// Shared definitions for the ADC capture controller: FSM state encoding and
// parameter defaults, reused by the capture block and the display/readback logic.
package adc_capture_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_INTR = 3'd2,
        READ      = 3'd3,
        LATCH     = 3'd4
    } adc_state_t;

    localparam int DEF_SAMPLE_DIV      = 1_000_000;
    localparam int DEF_WR_LOW_CYCLES   = 10;
    localparam int DEF_RD_SETUP_CYCLES = 20;
    localparam int DEF_INTR_TIMEOUT    = 20_000;
    localparam int DEF_ADDR_W          = 10;

    // Largest of three cycle counts, used to size the shared phase counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/adc_capture_ctrl_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Both flops load RESET_VAL on reset so an idle-high input reads as idle.
module adc_capture_ctrl_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic meta;

    // Two-stage resynchronization into the clk domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            dout <= RESET_VAL;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Periodic capture controller for an 8-bit parallel ADC with WR/INTR/RD
// handshake. Each sample tick starts one conversion; the result is written
// to a circular sample memory. All ADC strobes come straight from flops.
module adc_capture_ctrl
    import adc_capture_ctrl_pkg::*;
#(
    parameter int SAMPLE_DIV      = DEF_SAMPLE_DIV,
    parameter int WR_LOW_CYCLES   = DEF_WR_LOW_CYCLES,
    parameter int RD_SETUP_CYCLES = DEF_RD_SETUP_CYCLES,
    parameter int INTR_TIMEOUT    = DEF_INTR_TIMEOUT,
    parameter int ADDR_W          = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [7:0]        adc_data,
    input  logic              adc_intr_n,
    output logic              adc_cs_n,
    output logic              adc_wr_n,
    output logic              adc_rd_n,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              sample_valid,
    output logic              wrap_pulse,
    output logic              busy,
    output logic              timeout_err,
    output logic              overrun_err
);

    localparam int DIV_W     = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int PHASE_MAX = max3(WR_LOW_CYCLES, RD_SETUP_CYCLES, INTR_TIMEOUT);
    localparam int PHASE_W   = $clog2(PHASE_MAX + 1);

    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [PHASE_W-1:0] WR_LAST  = PHASE_W'(WR_LOW_CYCLES - 1);
    localparam logic [PHASE_W-1:0] RD_LAST  = PHASE_W'(RD_SETUP_CYCLES - 1);
    localparam logic [PHASE_W-1:0] TO_LAST  = PHASE_W'(INTR_TIMEOUT - 1);

    adc_state_t         state;
    adc_state_t         state_next;
    logic [DIV_W-1:0]   div_cnt;
    logic [PHASE_W-1:0] phase;
    logic               tick;
    logic               intr_sync;
    logic               timeout_hit;
    logic               cs_n_next;
    logic               wr_n_next;
    logic               rd_n_next;
    logic               latch_next;

    // The end-of-conversion line is asynchronous to clk.
    adc_capture_ctrl_sync #(
        .RESET_VAL (1'b1)
    ) u_intr_sync (
        .clk   (clk),
        .reset (reset),
        .din   (adc_intr_n),
        .dout  (intr_sync)
    );

    assign tick = enable && (div_cnt == DIV_LAST);
    assign busy = (state != IDLE);

    // Sample-rate divider: free-runs while enabled, parked at zero otherwise.
    always_ff @(posedge clk) begin
        if (reset || !enable || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Next-state and next-strobe decode; strobes are registered from this.
    always_comb begin
        state_next  = state;
        timeout_hit = 1'b0;
        unique case (state)
            IDLE:      if (tick) state_next = START;
            START:     if (phase == WR_LAST) state_next = WAIT_INTR;
            WAIT_INTR: begin
                if (!intr_sync) begin
                    state_next = READ;
                end else if (phase == TO_LAST) begin
                    state_next  = IDLE;
                    timeout_hit = 1'b1;
                end
            end
            READ:      if (phase == RD_LAST) state_next = LATCH;
            LATCH:     state_next = IDLE;
            default:   state_next = IDLE;
        endcase
        cs_n_next  = !((state_next == START) || (state_next == WAIT_INTR) || (state_next == READ));
        wr_n_next  = (state_next != START);
        rd_n_next  = (state_next != READ);
        latch_next = (state_next == LATCH);
    end

    // State register plus per-state cycle counter, restarted on every transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            phase <= '0;
        end else begin
            state <= state_next;
            if ((state_next != state) || (state == IDLE)) begin
                phase <= '0;
            end else begin
                phase <= phase + 1'b1;
            end
        end
    end

    // Registered strobes, memory write port and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            adc_cs_n     <= 1'b1;
            adc_wr_n     <= 1'b1;
            adc_rd_n     <= 1'b1;
            mem_we       <= 1'b0;
            sample_valid <= 1'b0;
            wrap_pulse   <= 1'b0;
            mem_addr     <= '0;
            mem_din      <= '0;
            timeout_err  <= 1'b0;
            overrun_err  <= 1'b0;
        end else begin
            adc_cs_n     <= cs_n_next;
            adc_wr_n     <= wr_n_next;
            adc_rd_n     <= rd_n_next;
            mem_we       <= latch_next;
            sample_valid <= latch_next;
            wrap_pulse   <= latch_next && (&mem_addr);
            if ((state == READ) && latch_next) begin
                mem_din <= adc_data;
            end
            if (state == LATCH) begin
                mem_addr <= mem_addr + 1'b1;
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
            if (tick && busy) begin
                overrun_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Self-checking bench for adc_capture_ctrl. Instance A (SAMPLE_DIV=100) covers
// reset, normal conversions, address wrap, timeout, reset mid-READ and enable
// drop. Instance B (SAMPLE_DIV=40, slow ADC) covers overrun.
module tb_adc_capture_ctrl;

    localparam int WR_LOW   = 4;
    localparam int RD_SETUP = 3;
    localparam int TIMEOUT  = 50;
    localparam int AW       = 3;
    localparam int DEPTH    = 1 << AW;
    localparam int B_DELAY  = 45;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A signals
    logic          a_reset, a_enable, a_intr_n;
    logic [7:0]    a_adc_data;
    logic          a_cs_n, a_wr_n, a_rd_n, a_mem_we, a_sample_valid, a_wrap_pulse;
    logic          a_busy, a_timeout_err, a_overrun_err;
    logic [AW-1:0] a_mem_addr;
    logic [7:0]    a_mem_din;

    // Instance B signals
    logic          b_reset, b_enable, b_intr_n;
    logic [7:0]    b_adc_data;
    logic          b_cs_n, b_wr_n, b_rd_n, b_mem_we, b_sample_valid, b_wrap_pulse;
    logic          b_busy, b_timeout_err, b_overrun_err;
    logic [AW-1:0] b_mem_addr;
    logic [7:0]    b_mem_din;

    // ADC model knobs for A, and the bench's view of where the next sample lands
    logic [7:0] a_val   = 8'h00;
    int         a_delay = 10;
    int         exp_addr = 0;
    int         a_last_wr_low = 0;
    int         a_last_rd_low = 0;
    int         a_last_wait   = 0;

    // B statistics gathered by its ADC model
    int         b_starts = 0;
    int         b_writes = 0;
    int         b_bad    = 0;

    adc_capture_ctrl #(
        .SAMPLE_DIV(100), .WR_LOW_CYCLES(WR_LOW), .RD_SETUP_CYCLES(RD_SETUP),
        .INTR_TIMEOUT(TIMEOUT), .ADDR_W(AW)
    ) dut_a (
        .clk(clk), .reset(a_reset), .enable(a_enable), .adc_data(a_adc_data),
        .adc_intr_n(a_intr_n), .adc_cs_n(a_cs_n), .adc_wr_n(a_wr_n), .adc_rd_n(a_rd_n),
        .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_din(a_mem_din),
        .sample_valid(a_sample_valid), .wrap_pulse(a_wrap_pulse), .busy(a_busy),
        .timeout_err(a_timeout_err), .overrun_err(a_overrun_err)
    );

    adc_capture_ctrl #(
        .SAMPLE_DIV(40), .WR_LOW_CYCLES(WR_LOW), .RD_SETUP_CYCLES(RD_SETUP),
        .INTR_TIMEOUT(TIMEOUT), .ADDR_W(AW)
    ) dut_b (
        .clk(clk), .reset(b_reset), .enable(b_enable), .adc_data(b_adc_data),
        .adc_intr_n(b_intr_n), .adc_cs_n(b_cs_n), .adc_wr_n(b_wr_n), .adc_rd_n(b_rd_n),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_din(b_mem_din),
        .sample_valid(b_sample_valid), .wrap_pulse(b_wrap_pulse), .busy(b_busy),
        .timeout_err(b_timeout_err), .overrun_err(b_overrun_err)
    );

    // ADC A behaviour: raise INTR a_delay cycles after WR rises (never if a_delay<=0),
    // release it on RD or deselect; data only settles on the last RD setup cycle.
    initial begin
        logic prev_wr;
        bit   armed;
        int   wcnt, wr_run, rd_run, wait_run;
        prev_wr = 1'b1; armed = 1'b0; wcnt = 0; wr_run = 0; rd_run = 0; wait_run = 0;
        a_intr_n = 1'b1;
        a_adc_data = 8'hFF;
        forever begin
            @(negedge clk);
            if (!a_wr_n) wr_run++;
            else if (wr_run != 0) begin a_last_wr_low = wr_run; wr_run = 0; end
            if (!a_rd_n) rd_run++;
            else if (rd_run != 0) begin a_last_rd_low = rd_run; rd_run = 0; end
            if (!a_cs_n && a_wr_n && a_rd_n) wait_run++;
            else if (wait_run != 0) begin a_last_wait = wait_run; wait_run = 0; end
            if (!prev_wr && a_wr_n) begin armed = 1'b1; wcnt = 0; end
            if (armed) begin
                wcnt++;
                if (a_delay > 0 && wcnt >= a_delay) begin a_intr_n = 1'b0; armed = 1'b0; end
            end
            if (!a_rd_n || a_cs_n) begin a_intr_n = 1'b1; armed = 1'b0; end
            a_adc_data = (rd_run == RD_SETUP) ? a_val : ~a_val;
            prev_wr = a_wr_n;
        end
    end

    // ADC B behaviour: slow converter (B_DELAY cycles); also tallies starts/writes
    // and checks every write against a simple running address/data expectation.
    initial begin
        logic       prev_wr;
        bit         armed;
        int         wcnt, b_exp_addr;
        logic [7:0] b_val;
        prev_wr = 1'b1; armed = 1'b0; wcnt = 0; b_exp_addr = 0; b_val = 8'h3C;
        b_intr_n = 1'b1;
        b_adc_data = b_val;
        forever begin
            @(negedge clk);
            if (prev_wr && !b_wr_n) b_starts++;
            if (b_mem_we) begin
                b_writes++;
                if (b_mem_din !== b_val || 32'(b_mem_addr) !== b_exp_addr) b_bad++;
                b_exp_addr = (b_exp_addr + 1) % DEPTH;
                b_val = b_val + 8'd17;
            end
            if (!prev_wr && b_wr_n) begin armed = 1'b1; wcnt = 0; end
            if (armed) begin
                wcnt++;
                if (wcnt >= B_DELAY) begin b_intr_n = 1'b0; armed = 1'b0; end
            end
            if (!b_rd_n || b_cs_n) begin b_intr_n = 1'b1; armed = 1'b0; end
            b_adc_data = b_val;
            prev_wr = b_wr_n;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] val, input int delay);
        a_val   = val;
        a_delay = delay;
    endtask

    task automatic wait_a_write(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (a_mem_we) begin seen = 1'b1; break; end
        end
    endtask

    // One full conversion on A, checked against the expected write.
    task automatic run_conversion(input string tag, input logic [7:0] val, input int delay);
        bit seen;
        apply_stimulus(val, delay);
        wait_a_write(300, seen);
        check_output({tag, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check_output({tag, "_addr"}, 32'(a_mem_addr), 32'(exp_addr));
            check_output({tag, "_din"}, 32'(a_mem_din), 32'(val));
            check_output({tag, "_valid"}, 32'(a_sample_valid), 32'd1);
            check_output({tag, "_wrap"}, 32'(a_wrap_pulse), 32'(exp_addr == DEPTH - 1));
            check_output({tag, "_wr_width"}, 32'(a_last_wr_low), 32'(WR_LOW));
            exp_addr = (exp_addr + 1) % DEPTH;
            @(negedge clk);
            check_output({tag, "_rd_width"}, 32'(a_last_rd_low), 32'(RD_SETUP));
            check_output({tag, "_addr_next"}, 32'(a_mem_addr), 32'(exp_addr));
            check_output({tag, "_we_off"}, 32'(a_mem_we), 32'd0);
        end
    endtask

    initial begin
        bit seen, we_seen, found;
        int n, cs_low, we_cnt;
        logic [7:0] v;

        a_reset = 1'b1; b_reset = 1'b1; a_enable = 1'b0; b_enable = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check_output("rst_cs_n", 32'(a_cs_n), 32'd1);
        check_output("rst_wr_n", 32'(a_wr_n), 32'd1);
        check_output("rst_rd_n", 32'(a_rd_n), 32'd1);
        check_output("rst_we", 32'(a_mem_we), 32'd0);
        check_output("rst_valid", 32'(a_sample_valid), 32'd0);
        check_output("rst_wrap", 32'(a_wrap_pulse), 32'd0);
        check_output("rst_addr", 32'(a_mem_addr), 32'd0);
        check_output("rst_din", 32'(a_mem_din), 32'd0);
        check_output("rst_busy", 32'(a_busy), 32'd0);
        check_output("rst_terr", 32'(a_timeout_err), 32'd0);
        check_output("rst_oerr", 32'(a_overrun_err), 32'd0);
        a_reset = 1'b0; b_reset = 1'b0;

        // Disabled: nothing happens
        cs_low = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (!a_cs_n) cs_low++;
        end
        check_output("disabled_cs_activity", 32'(cs_low), 32'd0);

        // Normal conversion, then eight random conversions through the wrap
        exp_addr = 0;
        a_enable = 1'b1;
        run_conversion("normal", 8'hA5, 10);
        for (int i = 1; i <= DEPTH; i++) begin
            run_conversion("wrap", 8'($urandom), int'($urandom_range(1, 30)));
        end

        // Timeout: INTR never comes
        apply_stimulus(8'h5A, -1);
        seen = 1'b0; we_seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (a_mem_we) we_seen = 1'b1;
            if (a_timeout_err) begin seen = 1'b1; break; end
        end
        check_output("timeout_seen", 32'(seen), 32'd1);
        check_output("timeout_no_write", 32'(we_seen), 32'd0);
        check_output("timeout_addr", 32'(a_mem_addr), 32'(exp_addr));
        check_output("timeout_busy", 32'(a_busy), 32'd0);
        @(negedge clk);
        check_output("timeout_wait_cycles", 32'(a_last_wait), 32'(TIMEOUT));
        run_conversion("after_timeout", 8'($urandom), 10);
        check_output("timeout_sticky", 32'(a_timeout_err), 32'd1);

        // Reset during the second READ cycle
        apply_stimulus(8'($urandom), 10);
        n = 0; found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!a_rd_n) n++;
            if (n == 2) begin found = 1'b1; break; end
        end
        check_output("rst_read_found", 32'(found), 32'd1);
        a_reset = 1'b1;
        @(posedge clk); #1;
        check_output("midrd_cs_n", 32'(a_cs_n), 32'd1);
        check_output("midrd_wr_n", 32'(a_wr_n), 32'd1);
        check_output("midrd_rd_n", 32'(a_rd_n), 32'd1);
        check_output("midrd_we", 32'(a_mem_we), 32'd0);
        check_output("midrd_addr", 32'(a_mem_addr), 32'd0);
        check_output("midrd_terr", 32'(a_timeout_err), 32'd0);
        check_output("midrd_oerr", 32'(a_overrun_err), 32'd0);
        check_output("midrd_busy", 32'(a_busy), 32'd0);
        @(negedge clk);
        a_reset = 1'b0;
        exp_addr = 0;

        // Enable dropped while waiting for INTR
        v = 8'($urandom);
        apply_stimulus(v, 20);
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!a_cs_n && a_wr_n && a_rd_n) begin found = 1'b1; break; end
        end
        check_output("endrop_wait_found", 32'(found), 32'd1);
        check_output("endrop_busy", 32'(a_busy), 32'd1);
        a_enable = 1'b0;
        run_conversion("endrop", v, 20);
        cs_low = 0; we_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!a_cs_n) cs_low++;
            if (a_mem_we) we_cnt++;
        end
        check_output("endrop_cs_quiet", 32'(cs_low), 32'd0);
        check_output("endrop_we_quiet", 32'(we_cnt), 32'd0);
        check_output("a_no_overrun", 32'(a_overrun_err), 32'd0);

        // Overrun on B: conversions longer than the sample period
        check_output("b_oerr_initial", 32'(b_overrun_err), 32'd0);
        b_enable = 1'b1;
        repeat (400) @(negedge clk);
        b_enable = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!b_busy) begin found = 1'b1; break; end
        end
        repeat (2) @(negedge clk);
        check_output("b_idle_after_drop", 32'(found), 32'd1);
        check_output("b_overrun", 32'(b_overrun_err), 32'd1);
        check_output("b_some_starts", 32'(b_starts >= 2), 32'd1);
        check_output("b_one_write_per_conv", 32'(b_writes), 32'(b_starts));
        check_output("b_write_contents", 32'(b_bad), 32'd0);
        check_output("b_no_timeout", 32'(b_timeout_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
